// File: rtl/tap_tempo_seq.sv
// Tap-tempo controller: tap interval -> divide request -> latched BPM; request one cycle after the press, one outstanding request.
// Presses during a pending divide are folded into a single follow-up request; TAP_AVG_EN enables interval averaging.
module tap_tempo_seq #(
   parameter int PER_W    = 24,
   parameter int PER_MAX  = 11718750,
   parameter int BPM_W    = 8,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tp_i,
   input  logic             btn_i,
   output logic [PER_W-1:0] btn_per_o,
   output logic             btn_per_valid_o,
   input  logic [BPM_W-1:0] bpm_i,
   input  logic             bpm_valid_i,
   output logic [BPM_W-1:0] bpm_o,
   output logic             bpm_update_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REQ, S_WAIT} state_t;

   localparam logic [PER_W-1:0] PMAX = PER_W'(PER_MAX);

   state_t           state;
   logic [PER_W-1:0] cnt;
   logic [PER_W-1:0] cnt_inc;
   logic [PER_W-1:0] new_per;
   logic [PER_W-1:0] req_val;
   logic             pending;
   logic             cap;
   logic             timeout;

   // A tick coincident with a press belongs to the interval being closed.
   always_comb begin
      cnt_inc = (cnt == PMAX) ? PMAX : cnt + PER_W'(tp_i);
      new_per = (cnt_inc == '0) ? PER_W'(1) : cnt_inc;
      cap     = btn_i && (state != S_IDLE);
      timeout = (state == S_COUNT) && !btn_i && (cnt == PMAX);
   end

`ifdef TAP_AVG_EN
   localparam int DEPTH  = 1 << AVG_LOG2;
   localparam int SUM_W  = PER_W + AVG_LOG2;
   localparam int FILL_W = $clog2(DEPTH + 1);

   logic [PER_W-1:0]  hist [DEPTH];
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  sum_nxt;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_nxt;

   // Request value is taken from the post-capture history so a press and its request line up.
   always_comb begin
      sum_nxt  = sum;
      fill_nxt = fill;
      if (cap) begin
         sum_nxt  = sum + SUM_W'(new_per) - SUM_W'(hist[DEPTH-1]);
         fill_nxt = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
      end
      if (fill_nxt == FILL_W'(DEPTH))
         req_val = PER_W'(sum_nxt >> AVG_LOG2);
      else
         req_val = cap ? new_per : hist[0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || timeout) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         sum  <= '0;
         fill <= '0;
      end else if (cap) begin
         hist[0] <= new_per;
         for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
         sum  <= sum_nxt;
         fill <= fill_nxt;
      end
   end
`else
   localparam int unused_avg_log2 = AVG_LOG2;

   logic [PER_W-1:0] last_per;

   always_comb req_val = cap ? new_per : last_per;

   always_ff @(posedge clk_i) begin
      if (rst_i || timeout)
         last_per <= '0;
      else if (cap)
         last_per <= new_per;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         cnt             <= '0;
         pending         <= 1'b0;
         btn_per_o       <= '0;
         btn_per_valid_o <= 1'b0;
         bpm_o           <= '0;
         bpm_update_o    <= 1'b0;
      end else begin
         btn_per_valid_o <= 1'b0;
         bpm_update_o    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (btn_i) begin
                  cnt   <= '0;
                  state <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (btn_i) begin
                  cnt             <= '0;
                  btn_per_o       <= req_val;
                  btn_per_valid_o <= 1'b1;
                  state           <= S_REQ;
               end else if (cnt == PMAX) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_REQ: begin
               state <= S_WAIT;
               if (btn_i) begin
                  cnt     <= '0;
                  pending <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_WAIT: begin
               cnt <= btn_i ? '0 : cnt_inc;
               // Saturation here is not a timeout; S_COUNT checks it once the result is in.
               if (bpm_valid_i) begin
                  bpm_o        <= bpm_i;
                  bpm_update_o <= 1'b1;
                  if (pending || btn_i) begin
                     pending         <= 1'b0;
                     btn_per_o       <= req_val;
                     btn_per_valid_o <= 1'b1;
                     state           <= S_REQ;
                  end else begin
                     state <= S_COUNT;
                  end
               end else if (btn_i) begin
                  pending <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_tap_tempo_seq.sv
// Bench for tap_tempo_seq: vector table, directed multi-cycle sequences, randomized run against a queue-based model.
module tb_tap_tempo_seq;
   localparam int PER_W    = 24;
   localparam int BPM_W    = 8;
   localparam int AVG_LOG2 = 2;
   localparam int PMAX     = 3000;
   localparam int DEPTH    = 1 << AVG_LOG2;

   logic             clk_i = 1'b0;
   logic             rst_i, tp_i, btn_i, bpm_valid_i;
   logic [BPM_W-1:0] bpm_i;
   logic [PER_W-1:0] btn_per_o;
   logic             btn_per_valid_o;
   logic [BPM_W-1:0] bpm_o;
   logic             bpm_update_o, busy_o;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   tap_tempo_seq #(.PER_W(PER_W), .PER_MAX(PMAX), .BPM_W(BPM_W), .AVG_LOG2(AVG_LOG2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .btn_i(btn_i),
      .btn_per_o(btn_per_o), .btn_per_valid_o(btn_per_valid_o),
      .bpm_i(bpm_i), .bpm_valid_i(bpm_valid_i),
      .bpm_o(bpm_o), .bpm_update_o(bpm_update_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]       in;     // {rst, tp, btn, bpm_valid}
      logic [7:0]       bpm;
      logic [2:0]       ef;     // {valid, update, busy}
      logic [PER_W-1:0] eper;
      logic [7:0]       ebpm;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic [3:0] in, input logic [7:0] bpm, input logic [2:0] ef,
                               input logic [PER_W-1:0] eper, input logic [7:0] ebpm);
      vec_t v;
      v.in = in; v.bpm = bpm; v.ef = ef; v.eper = eper; v.ebpm = ebpm;
      return v;
   endfunction

   task automatic drive(input int r, input int t, input int b, input int v, input int d);
      rst_i = (r != 0); tp_i = (t != 0); btn_i = (b != 0); bpm_valid_i = (v != 0); bpm_i = 8'(d);
      @(posedge clk_i);
      #1;
   endtask

   task automatic run(input int n, input int t, output int nv);
      nv = 0;
      for (int i = 0; i < n; i++) begin
         drive(0, t, 0, 0, 0);
         if (btn_per_valid_o) nv++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference model: tracks the tap interval and the set of recent periods as plain numbers.
   logic             m_active, m_wait, m_reqnow, m_pend, m_v, m_upd;
   int               m_ival;
   int               m_hist[$];
   logic [PER_W-1:0] m_per;
   logic [7:0]       m_bpm;

   function automatic int req_value();
      int s;
`ifdef TAP_AVG_EN
      if (m_hist.size() < DEPTH) return m_hist[$];
      s = 0;
      foreach (m_hist[i]) s += m_hist[i];
      return s / DEPTH;
`else
      s = m_hist[$];
      return s;
`endif
   endfunction

   function automatic void fire();
      m_wait = 1'b1; m_v = 1'b1; m_per = PER_W'(req_value());
   endfunction

   function automatic void model_step(input logic r, input logic t, input logic b, input logic bv, input logic [7:0] d);
      int old, p;
      m_v = 1'b0; m_upd = 1'b0;
      if (r) begin
         m_active = 0; m_wait = 0; m_pend = 0; m_ival = 0; m_hist.delete(); m_per = '0; m_bpm = '0;
      end else if (!m_active) begin
         if (b) begin m_active = 1'b1; m_ival = 0; end
      end else begin
         old = m_ival;
         p = (m_ival + (t ? 1 : 0) > PMAX) ? PMAX : m_ival + (t ? 1 : 0);
         if (b) begin
            m_hist.push_back(p == 0 ? 1 : p);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            m_ival = 0;
         end else begin
            m_ival = p;
         end
         if (!m_wait) begin
            if (b) fire();
            else if (old == PMAX) begin m_active = 1'b0; m_hist.delete(); m_ival = 0; end
         end else if (m_reqnow) begin
            if (b) m_pend = 1'b1;
         end else if (bv) begin
            m_bpm = d; m_upd = 1'b1;
            if (m_pend || b) begin m_pend = 1'b0; fire(); end
            else m_wait = 1'b0;
         end else if (b) begin
            m_pend = 1'b1;
         end
      end
      m_reqnow = m_v;
   endfunction

   initial begin
      int nv, press_div, resp_cd;
      int ivl[4];
      int avg_exp[4];
      logic r, t, b, bv;
      logic [7:0] d;

      rst_i = 1'b0; tp_i = 1'b0; btn_i = 1'b0; bpm_valid_i = 1'b0; bpm_i = '0;

      tbl[0]  = mk(4'b1000, 8'd0,   3'b000, 24'd0, 8'd0);
      tbl[1]  = mk(4'b0010, 8'd0,   3'b001, 24'd0, 8'd0);
      tbl[2]  = mk(4'b0100, 8'd0,   3'b001, 24'd0, 8'd0);
      tbl[3]  = mk(4'b0100, 8'd0,   3'b001, 24'd0, 8'd0);
      tbl[4]  = mk(4'b0110, 8'd0,   3'b101, 24'd3, 8'd0);
      tbl[5]  = mk(4'b0000, 8'd0,   3'b001, 24'd3, 8'd0);
      tbl[6]  = mk(4'b0001, 8'd200, 3'b011, 24'd3, 8'd200);
      tbl[7]  = mk(4'b0000, 8'd0,   3'b001, 24'd3, 8'd200);
      tbl[8]  = mk(4'b0010, 8'd0,   3'b101, 24'd1, 8'd200);
      tbl[9]  = mk(4'b0100, 8'd0,   3'b001, 24'd1, 8'd200);
      tbl[10] = mk(4'b0111, 8'd55,  3'b111, 24'd2, 8'd55);
      tbl[11] = mk(4'b0000, 8'd0,   3'b001, 24'd2, 8'd55);
      tbl[12] = mk(4'b1001, 8'd9,   3'b000, 24'd0, 8'd0);
      tbl[13] = mk(4'b0001, 8'd77,  3'b000, 24'd0, 8'd0);

      for (int i = 0; i < 14; i++) begin
         drive(int'(tbl[i].in[3]), int'(tbl[i].in[2]), int'(tbl[i].in[1]), int'(tbl[i].in[0]), int'(tbl[i].bpm));
         chk($sformatf("tbl[%0d] valid", i), 32'(btn_per_valid_o), 32'(tbl[i].ef[2]));
         chk($sformatf("tbl[%0d] update", i), 32'(bpm_update_o), 32'(tbl[i].ef[1]));
         chk($sformatf("tbl[%0d] busy", i), 32'(busy_o), 32'(tbl[i].ef[0]));
         chk($sformatf("tbl[%0d] per", i), 32'(btn_per_o), 32'(tbl[i].eper));
         chk($sformatf("tbl[%0d] bpm", i), 32'(bpm_o), 32'(tbl[i].ebpm));
      end

      // First tap, then a 1000-tick interval closed by a coincident tick.
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      chk("first tap busy", 32'(busy_o), 32'd1);
      chk("first tap no request", 32'(btn_per_valid_o), 32'd0);
      run(999, 1, nv);
      chk("no request while counting", 32'(nv), 32'd0);
      drive(0, 1, 1, 0, 0);
      chk("second tap valid", 32'(btn_per_valid_o), 32'd1);
      chk("second tap period", 32'(btn_per_o), 32'd1000);
      drive(0, 0, 0, 0, 0);
      chk("request single cycle", 32'(btn_per_valid_o), 32'd0);
      run(29, 0, nv);
      drive(0, 0, 0, 1, 120);
      chk("bpm latched", 32'(bpm_o), 32'd120);
      chk("bpm update pulse", 32'(bpm_update_o), 32'd1);
      drive(0, 0, 0, 0, 0);
      chk("bpm update one cycle", 32'(bpm_update_o), 32'd0);
      chk("bpm held", 32'(bpm_o), 32'd120);
      run(7, 1, nv);
      drive(0, 0, 1, 0, 0);
      chk("cnt restarted", 32'(btn_per_o), 32'd7);

      // Press during a slow divide: one follow-up request after the result.
      run(499, 1, nv);
      drive(0, 1, 1, 0, 0);
      chk("press in wait no request", 32'(btn_per_valid_o), 32'd0);
      run(200, 0, nv);
      chk("no request before result", 32'(nv), 32'd0);
      drive(0, 0, 0, 1, 150);
      chk("pending request valid", 32'(btn_per_valid_o), 32'd1);
      chk("pending request period", 32'(btn_per_o), 32'd500);
      chk("pending result bpm", 32'(bpm_o), 32'd150);
      run(40, 0, nv);
      chk("exactly one follow-up", 32'(nv), 32'd0);
      drive(0, 0, 0, 1, 151);

      // Silence timeout.
      run(PMAX, 1, nv);
      chk("busy at saturation", 32'(busy_o), 32'd1);
      drive(0, 1, 0, 0, 0);
      chk("timeout busy", 32'(busy_o), 32'd0);
      chk("timeout bpm held", 32'(bpm_o), 32'd151);
      drive(0, 0, 1, 0, 0);
      chk("tap after timeout no request", 32'(btn_per_valid_o), 32'd0);
      chk("tap after timeout busy", 32'(busy_o), 32'd1);
      run(19, 1, nv);
      drive(0, 1, 1, 0, 0);
      chk("post-timeout period", 32'(btn_per_o), 32'd20);

      // Saturation during the divide, timeout deferred to the counting state.
      run(PMAX + 50, 1, nv);
      chk("no timeout in wait", 32'(busy_o), 32'd1);
      chk("no request in wait", 32'(nv), 32'd0);
      drive(0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 60);
      chk("saturated request valid", 32'(btn_per_valid_o), 32'd1);
      chk("saturated period", 32'(btn_per_o), 32'(PMAX));
      run(PMAX + 5, 1, nv);
      drive(0, 0, 0, 1, 61);
      chk("busy after late result", 32'(busy_o), 32'd1);
      drive(0, 0, 0, 0, 0);
      chk("deferred timeout", 32'(busy_o), 32'd0);

      // Averaging (or latest period without it).
      ivl = '{1000, 1000, 1000, 1004};
`ifdef TAP_AVG_EN
      avg_exp = '{1000, 1000, 1000, 1001};
`else
      avg_exp = '{1000, 1000, 1000, 1004};
`endif
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         run(ivl[k] - 1, 1, nv);
         drive(0, 1, 1, 0, 0);
         chk($sformatf("avg[%0d] valid", k), 32'(btn_per_valid_o), 32'd1);
         chk($sformatf("avg[%0d] period", k), 32'(btn_per_o), 32'(avg_exp[k]));
         drive(0, 0, 0, 0, 0);
         drive(0, 0, 0, 1, 100);
      end

      // Randomized run against the model.
      drive(1, 0, 0, 0, 0);
      model_step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      resp_cd = 0;
      for (int i = 0; i < 20000; i++) begin
         case (i / 5000)
            0: press_div = 30;
            1: press_div = 5;
            2: press_div = 300;
            default: press_div = 4000;
         endcase
         r  = ($urandom_range(0, 2999) == 0);
         t  = ($urandom_range(0, 3) != 0);
         b  = !m_reqnow && ($urandom_range(0, press_div - 1) == 0);
         d  = 8'($urandom);
         bv = 1'b0;
         if (m_wait && !m_reqnow) begin
            if (resp_cd == 0) bv = 1'b1;
            else resp_cd--;
         end else if (!m_wait) begin
            bv = ($urandom_range(0, 99) == 0);
         end
         drive(int'(r), int'(t), int'(b), int'(bv), int'(d));
         model_step(r, t, b, bv, d);
         if (m_v) resp_cd = $urandom_range(0, 40);
         vec_cnt++;
         if (btn_per_valid_o !== m_v || btn_per_o !== m_per || bpm_o !== m_bpm ||
             bpm_update_o !== m_upd || busy_o !== m_active) begin
            miss_cnt++;
            $display("FAIL rand cycle %0d: got v=%0b per=%0d bpm=%0d upd=%0b busy=%0b, expected v=%0b per=%0d bpm=%0d upd=%0b busy=%0b",
                     i, btn_per_valid_o, btn_per_o, bpm_o, bpm_update_o, busy_o,
                     m_v, m_per, m_bpm, m_upd, m_active);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
